// File: rtl/tw_pkg.sv
// Shared types and helpers for the multi-lane twiddle sequencer.
// TW_LANE_GEN_MONT_EN selects R_W as the identity word instead of 1.
package tw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } tw_state_e;

  // Twiddle table source: successive powers of a root of unity mod 7681
  localparam logic [63:0] TW_ROM_Q    = 64'd7681;
  localparam logic [63:0] TW_ROM_ROOT = 64'd3383;

  function automatic int tw_beats(input int logn, input int lanes);
    return (1 << (logn - 1)) / lanes;
  endfunction

  function automatic logic [63:0] tw_id(input logic [63:0] r_w);
`ifdef TW_LANE_GEN_MONT_EN
    return r_w;
`else
    return 64'd1 | (r_w & 64'd0);
`endif
  endfunction

  function automatic int tw_lane_lsb(input int l, input int logq);
    return l * logq;
  endfunction

  function automatic logic [63:0] tw_modpow(
    input logic [63:0] b,
    input logic [63:0] e,
    input logic [63:0] m
  );
    logic [63:0] r;
    logic [63:0] x;
    r = 64'd1;
    x = b % m;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return r;
  endfunction

  // Later stages use a finer stride through the same root sequence
  function automatic logic [63:0] tw_rom_word(
    input int stage,
    input int logn,
    input int addr
  );
    int sh;
    sh = (stage >= logn - 1) ? 0 : (logn - 1 - stage);
    return tw_modpow(TW_ROM_ROOT, 64'(addr) << sh, TW_ROM_Q);
  endfunction

endpackage

// File: rtl/tw_rom_bank.sv
// Banked twiddle ROM: one bank per lane, clock-enabled read pipeline.
// Bank l holds the words whose address is congruent to l modulo LANES.
import tw_pkg::*;

module tw_rom_bank #(
  parameter int LOGQ       = 32,
  parameter int LOGN       = 12,
  parameter int LANES      = 2,
  parameter int STAGE      = 1,
  parameter int DELAY_BROM = 2,
  parameter int BEATS      = tw_beats(LOGN, LANES),
  parameter int AW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce_i,
  input  logic [AW-1:0]         addr_i,
  output logic [LANES*LOGQ-1:0] rdata_o
);

  logic [LANES*LOGQ-1:0] rd;
  logic [LANES*LOGQ-1:0] pipe_q [DELAY_BROM];

  for (genvar l = 0; l < LANES; l++) begin : g_bank
    logic [LOGQ-1:0] mem [BEATS];
    for (genvar b = 0; b < BEATS; b++) begin : g_word
      assign mem[b] = LOGQ'(tw_rom_word(STAGE, LOGN, b * LANES + l));
    end
    assign rd[l*LOGQ +: LOGQ] = mem[addr_i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DELAY_BROM; k++) pipe_q[k] <= '0;
    end else if (ce_i) begin
      pipe_q[0] <= rd;
      for (int k = 1; k < DELAY_BROM; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign rdata_o = pipe_q[DELAY_BROM-1];

endmodule

// File: rtl/tw_lane_gen.sv
// Multi-lane twiddle sequencer for one NTT/INTT butterfly stage.
// TW_LANE_GEN_MONT_EN: identity word is R_W (Montgomery one), else 1.
import tw_pkg::*;

module tw_lane_gen #(
  parameter int              LOGQ       = 32,
  parameter int              LOGN       = 12,
  parameter int              LANES      = 2,
  parameter int              STAGE      = 0,
  parameter int              DELAY_BROM = 2,
  parameter logic [LOGQ-1:0] R_W        = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  intt,
  input  logic [LOGQ-1:0]       q,
  output logic [LANES*LOGQ-1:0] tw_data,
  output logic                  tw_valid,
  input  logic                  tw_ready,
  output logic                  tw_last,
  output logic                  busy,
  output logic                  done
);

  localparam int BEATS = tw_beats(LOGN, LANES);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PL    = DELAY_BROM + 1;
  localparam logic [LOGQ-1:0] ID = LOGQ'(tw_id(64'(R_W)));

  tw_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  intt_q, intt_d;
  logic [LOGQ-1:0]       q_q, q_d;
  logic [PL-1:0]         vld_q, lst_q;
  logic [LANES*LOGQ-1:0] word;
  logic [LANES*LOGQ-1:0] data_q, data_d;
  logic                  valid_q, last_q;
  logic                  done_q, done_d;
  logic                  adv, issue, at_end, hs_last;

  assign adv     = ~valid_q | tw_ready;
  assign issue   = (state_q == RUN) & adv;
  assign at_end  = (cnt_q == CW'(BEATS - 1));
  assign hs_last = valid_q & tw_ready & last_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    intt_d  = intt_q;
    q_d     = q_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          intt_d  = intt;
          q_d     = q;
        end
      end
      RUN: begin
        if (issue) begin
          cnt_d = cnt_q + CW'(1);
          if (at_end) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  if (STAGE == 0) begin : g_id
    assign word = {LANES{ID}};
  end else begin : g_rom
    logic [CW-1:0] addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) addr_q <= '0;
      else if (issue) addr_q <= cnt_q;
    end

    tw_rom_bank #(
      .LOGQ       (LOGQ),
      .LOGN       (LOGN),
      .LANES      (LANES),
      .STAGE      (STAGE),
      .DELAY_BROM (DELAY_BROM),
      .BEATS      (BEATS),
      .AW         (CW)
    ) u_rom (
      .clk     (clk),
      .rst_n   (rst_n),
      .ce_i    (adv),
      .addr_i  (addr_q),
      .rdata_o (word)
    );
  end

  // Identity words are their own inverse; everything else becomes q - w
  always_comb begin
    data_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (intt_q && word[tw_lane_lsb(l, LOGQ) +: LOGQ] != ID)
        data_d[tw_lane_lsb(l, LOGQ) +: LOGQ] =
          q_q - word[tw_lane_lsb(l, LOGQ) +: LOGQ];
      else
        data_d[tw_lane_lsb(l, LOGQ) +: LOGQ] =
          word[tw_lane_lsb(l, LOGQ) +: LOGQ];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      intt_q  <= 1'b0;
      q_q     <= '0;
      vld_q   <= '0;
      lst_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      intt_q  <= intt_d;
      q_q     <= q_d;
      done_q  <= done_d;
      if (adv) begin
        vld_q   <= {vld_q[PL-2:0], issue};
        lst_q   <= {lst_q[PL-2:0], issue & at_end};
        valid_q <= vld_q[PL-1];
        last_q  <= lst_q[PL-1];
        data_q  <= data_d;
      end
    end
  end

  assign tw_data  = data_q;
  assign tw_valid = valid_q;
  assign tw_last  = last_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_tw_lane_gen.sv
// Bench for tw_lane_gen: a STAGE=3 ROM instance and a STAGE=0 identity
// instance share stimulus and are both checked against a sweep model.
module tb_tw_lane_gen;

  localparam int LOGQ  = 32;
  localparam int LOGN  = 4;
  localparam int LANES = 2;
  localparam int D     = 2;
  localparam int BEATS = 4;
  localparam longint QV = 7681;
`ifdef TW_LANE_GEN_MONT_EN
  localparam longint IDV = 511;
`else
  localparam longint IDV = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        intt = 1'b0;
  logic        tw_ready = 1'b1;
  logic [31:0] q = 32'd7681;

  logic [63:0] data_a, data_b;
  logic valid_a, last_a, busy_a, done_a;
  logic valid_b, last_b, busy_b, done_b;

  always #5 clk = ~clk;

  tw_lane_gen #(
    .LOGQ(LOGQ), .LOGN(LOGN), .LANES(LANES), .STAGE(3),
    .DELAY_BROM(D), .R_W(32'd511)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .intt(intt), .q(q),
    .tw_data(data_a), .tw_valid(valid_a), .tw_ready(tw_ready),
    .tw_last(last_a), .busy(busy_a), .done(done_a)
  );

  tw_lane_gen #(
    .LOGQ(LOGQ), .LOGN(LOGN), .LANES(LANES), .STAGE(0),
    .DELAY_BROM(D), .R_W(32'd511)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .intt(intt), .q(q),
    .tw_data(data_b), .tw_valid(valid_b), .tw_ready(tw_ready),
    .tw_last(last_b), .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input int u, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h", u, nm, act, exp);
    end
  endtask

  // Twiddle words from the rule: word a = 3383^a mod 7681
  function automatic logic [63:0] exp_beat(input int u, input int b,
                                           input logic inv);
    longint w;
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      w = 1;
      if (u == 0) begin
        for (int k = 0; k < b * LANES + l; k++) w = (w * 3383) % QV;
      end else begin
        w = IDV;
      end
      if (inv && w != IDV) w = QV - w;
      r[l*32 +: 32] = w[31:0];
    end
    return r;
  endfunction

  logic [63:0] dat [2];
  logic [1:0]  vld, lst, bsy, dn;
  assign dat[0] = data_a;
  assign dat[1] = data_b;
  assign vld = {valid_b, valid_a};
  assign lst = {last_b, last_a};
  assign bsy = {busy_b, busy_a};
  assign dn  = {done_b, done_a};

  int cyc = 0;
  int idx [2];
  int stalls [2];
  int start_cyc [2];
  int dones [2];
  bit m_busy [2];
  bit m_done [2];
  bit hold [2];
  bit first_pend [2];
  logic [63:0] hold_d [2];
  logic m_intt = 1'b0;
  logic [63:0] cap [BEATS];
  logic [63:0] capb;

  initial begin
    for (int u = 0; u < 2; u++) begin
      idx[u] = 0; stalls[u] = 0; start_cyc[u] = 0; dones[u] = 0;
      m_busy[u] = 0; m_done[u] = 0; hold[u] = 0; first_pend[u] = 0;
      hold_d[u] = '0;
    end
  end

  always @(negedge clk) begin
    bit hs, hs_end;
    cyc++;
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        chk(u, "rst_valid", vld[u], 0);
        chk(u, "rst_last", lst[u], 0);
        chk(u, "rst_busy", bsy[u], 0);
        chk(u, "rst_done", dn[u], 0);
        chk(u, "rst_data", dat[u], 0);
        m_busy[u] = 0; m_done[u] = 0; hold[u] = 0;
        first_pend[u] = 0; idx[u] = 0;
      end else begin
        chk(u, "busy", bsy[u], m_busy[u]);
        chk(u, "done", dn[u], m_done[u]);
        if (dn[u]) begin
          dones[u]++;
          chk(u, "sweep_len", cyc - start_cyc[u], BEATS + D + 3 + stalls[u]);
          chk(u, "beats_at_done", idx[u], BEATS);
        end
        if (hold[u]) begin
          chk(u, "stall_valid", vld[u], 1);
          chk(u, "stall_data", dat[u], hold_d[u]);
        end
        if (vld[u]) begin
          chk(u, "valid_in_sweep", m_busy[u], 1);
          if (first_pend[u]) begin
            chk(u, "first_latency", cyc - start_cyc[u], D + 3);
            first_pend[u] = 0;
          end
        end
        hs = vld[u] && tw_ready;
        hs_end = hs && (idx[u] == BEATS - 1);
        if (hs) begin
          chk(u, "beat_in_range", idx[u] < BEATS, 1);
          if (idx[u] < BEATS) begin
            chk(u, "beat_data", dat[u], exp_beat(u, idx[u], m_intt));
            chk(u, "beat_last", lst[u], idx[u] == BEATS - 1);
            if (u == 0) cap[idx[u]] = dat[u];
            else if (idx[u] == 0) capb = dat[u];
          end
          idx[u]++;
        end
        hold[u] = vld[u] && !tw_ready;
        hold_d[u] = dat[u];
        if (hold[u]) stalls[u]++;
        m_done[u] = hs_end;
        if (m_busy[u] && hs_end) begin
          m_busy[u] = 0;
        end else if (!m_busy[u] && start) begin
          m_busy[u] = 1; start_cyc[u] = cyc; idx[u] = 0;
          stalls[u] = 0; first_pend[u] = 1; m_intt = intt;
        end
      end
    end
  end

  bit stall_mode = 0;
  int pi = 0;
  logic [15:0] pat = 16'b1001_1101_0100_1011;

  always @(posedge clk) begin
    #1;
    if (stall_mode) begin
      tw_ready = pat[pi % 16];
      pi++;
    end
  end

  task automatic sweep(input logic inv, input bit midstart);
    int d0;
    bit seen;
    d0 = dones[0];
    @(posedge clk); #1;
    intt = inv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (midstart) begin
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #1;
      if (done_a) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL sweep_timeout: got no done expected done within 100 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
    chk(0, "done_count", dones[0] - d0, 1);
  endtask

  initial begin
    int d0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    sweep(1'b0, 1'b0);
    chk(0, "lit_fwd_b0", cap[0], {32'd3383, 32'd1});
    chk(0, "lit_fwd_b1", cap[1], {32'd4298, 32'd7680});
    chk(0, "lit_fwd_b3", cap[3], {32'd4298, 32'd7680});
    chk(1, "lit_id_b0", capb, {IDV[31:0], IDV[31:0]});

    sweep(1'b1, 1'b0);
`ifdef TW_LANE_GEN_MONT_EN
    chk(0, "lit_inv_b0", cap[0], {32'd4298, 32'd7680});
`else
    chk(0, "lit_inv_b0", cap[0], {32'd4298, 32'd1});
`endif
    chk(0, "lit_inv_b1", cap[1], {32'd3383, 32'd1});
    chk(1, "lit_id_inv_b0", capb, {IDV[31:0], IDV[31:0]});

    stall_mode = 1;
    sweep(1'b0, 1'b1);
    stall_mode = 0;
    #2 tw_ready = 1'b1;
    chk(0, "lit_stall_b2", cap[2], {32'd3383, 32'd1});

    d0 = dones[0];
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    chk(0, "abort_valid", valid_a, 0);
    chk(0, "abort_busy", busy_a, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk(0, "abort_no_done", dones[0] - d0, 0);

    sweep(1'b0, 1'b0);
    chk(0, "lit_after_abort_b0", cap[0], {32'd3383, 32'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
